// File: rtl/mtimer_periph_pkg.sv
// mtimer_pkg: shared constants and types for the machine-timer peripheral.
//   Register byte offsets within the 32-byte window, CTRL bit indices,
//   the word access-size code, and the interrupt FSM state type.
package mtimer_pkg;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_PRESCALE    = 5'h14;
    localparam logic [4:0] OFF_STATUS      = 5'h18;
    localparam logic [4:0] OFF_PERIOD      = 5'h1C;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IE       = 2;

    localparam logic [2:0] MEM_WORD = 3'b010;

    typedef enum logic [1:0] {IDLE, RUN, FIRED} tmr_state_e;

endpackage

// File: rtl/mtimer_periph_if.sv
// mtimer_periph_if: processor data-memory load/store bus as seen by the timer.
//   master: rd_en, wr_en, addr, wdata, mem_mode out; rdata, hit in
//   slave : the reverse (the timer is the responder)
interface mtimer_periph_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mem_mode;
    logic [31:0] rdata;
    logic        hit;

    modport master (output rd_en, wr_en, addr, wdata, mem_mode, input rdata, hit);
    modport slave  (input rd_en, wr_en, addr, wdata, mem_mode, output rdata, hit);
endinterface

// File: rtl/mtimer_periph_tick_gen.sv
// tick_gen: prescaler for the mtime counter.
//   clk, rst (async active-low), en (counting enable), prescale (period-1)
//   tick: one-cycle pulse every prescale+1 enabled cycles
module tick_gen #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);
    logic [PRESC_W-1:0] cnt_q, cnt_d;

    // >= so a PRESCALE lowered below the running count restarts the period
    // instead of wrapping the whole counter.
    assign tick  = en & (cnt_q >= prescale);
    assign cnt_d = (!en || tick) ? '0 : cnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mtimer_periph.sv
// mtimer_periph: memory-mapped machine timer with prescaler, 64-bit compare
// and one-shot/periodic interrupt.
//   clk, rst (async active-low)
//   bus    : load/store responder (combinational rdata, hit decode)
//   t_intr : timer interrupt, PEND & IE from flops
module mtimer_periph
    import mtimer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int          PRESC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    mtimer_periph_if.slave   bus,
    output logic             t_intr
);
    logic [63:0]        mtime_q, mtime_d, cmp_q, cmp_d, mtime_inc;
    logic [31:0]        shadow_q, shadow_d, period_q, period_d, rdata_c;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               pend_q, pend_d, t_intr_q;
    tmr_state_e         state_q;
    logic [4:0]         off;
    logic               tick, match, wr_ok, rd_ok, fire, pend_clr, cmp_wr, en;

    tick_gen #(.PRESC_W(PRESC_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[CTRL_EN]),
        .prescale (presc_q),
        .tick     (tick)
    );

    assign en        = ctrl_q[CTRL_EN];
    assign bus.hit   = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign off       = {bus.addr[4:2], 2'b00};
    assign wr_ok     = bus.wr_en & bus.hit & (bus.mem_mode == MEM_WORD);
    assign rd_ok     = bus.rd_en & bus.hit;
    assign match     = (mtime_q >= cmp_q);
    assign fire      = (state_q == RUN) & en & match;
    assign pend_clr  = wr_ok & (off == OFF_STATUS) & bus.wdata[0];
    assign cmp_wr    = wr_ok & ((off == OFF_MTIMECMP_LO) | (off == OFF_MTIMECMP_HI));
    assign mtime_inc = mtime_q + 64'(tick);
    assign t_intr    = t_intr_q;
    assign bus.rdata = rdata_c;

    // Bus writes override the increment / periodic reload for the written
    // half only; a LO write keeps the old HI, so no carry leaks through.
    always_comb begin
        mtime_d  = mtime_inc;
        cmp_d    = (fire & ctrl_q[CTRL_PERIODIC]) ? cmp_q + {32'b0, period_q} : cmp_q;
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        period_d = period_q;
        shadow_d = (rd_ok && off == OFF_MTIME_LO) ? mtime_q[63:32] : shadow_q;
        if (wr_ok) begin
            case (off)
                OFF_MTIME_LO:    mtime_d        = {mtime_q[63:32], bus.wdata};
                OFF_MTIME_HI:    mtime_d[63:32] = bus.wdata;
                OFF_MTIMECMP_LO: cmp_d[31:0]    = bus.wdata;
                OFF_MTIMECMP_HI: cmp_d[63:32]   = bus.wdata;
                OFF_CTRL:        ctrl_d         = bus.wdata[2:0];
                OFF_PRESCALE:    presc_d        = bus.wdata[PRESC_W-1:0];
                OFF_PERIOD:      period_d       = bus.wdata;
                default: ;
            endcase
        end
        pend_d = fire | (pend_q & ~pend_clr);   // set beats W1C
    end

    always_comb begin
        rdata_c = '0;
        if (rd_ok) begin
            case (off)
                OFF_MTIME_LO:    rdata_c = mtime_q[31:0];
                OFF_MTIME_HI:    rdata_c = shadow_q;
                OFF_MTIMECMP_LO: rdata_c = cmp_q[31:0];
                OFF_MTIMECMP_HI: rdata_c = cmp_q[63:32];
                OFF_CTRL:        rdata_c = {29'b0, ctrl_q};
                OFF_PRESCALE:    rdata_c = 32'(presc_q);
                OFF_STATUS:      rdata_c = {31'b0, pend_q};
                OFF_PERIOD:      rdata_c = period_q;
                default:         rdata_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q  <= '0;
            cmp_q    <= '1;
            ctrl_q   <= '0;
            presc_q  <= '0;
            period_q <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            t_intr_q <= 1'b0;
            state_q  <= IDLE;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            period_q <= period_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            t_intr_q <= pend_d & ctrl_d[CTRL_IE];
            if (!en) state_q <= IDLE;
            else begin
                case (state_q)
                    IDLE:    state_q <= RUN;
                    RUN:     if (match && !ctrl_q[CTRL_PERIODIC]) state_q <= FIRED;
                    FIRED:   if (pend_clr || cmp_wr) state_q <= RUN;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mtimer_periph.sv
// Bench for mtimer_periph: directed scenarios with literal expectations plus
// a randomized bus phase, all outputs compared every cycle to a model.
module tb_mtimer_periph;
    import mtimer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic t_intr;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   go    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mtimer_periph_if bus();

    mtimer_periph #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .t_intr (t_intr)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] mt;
        logic [63:0] cmp;
        logic [31:0] shadow;
        logic [31:0] period;
        logic [15:0] presc;
        logic [15:0] phase;   // cycles elapsed in current prescale period
        logic [2:0]  ctrl;
        logic        pend;
        logic        armed;   // EN was set during the previous cycle
        logic        fired;   // one-shot match taken, waiting for re-arm
        logic        tint;
    } mstate_t;

    localparam mstate_t M_RST = '{mt: 64'd0, cmp: '1, shadow: 32'd0, period: 32'd0,
                                  presc: 16'd0, phase: 16'd0, ctrl: 3'd0, pend: 1'b0,
                                  armed: 1'b0, fired: 1'b0, tint: 1'b0};

    mstate_t m = M_RST;

    function automatic logic [31:0] m_rdata(mstate_t s, logic rd, logic [31:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (rd && a[31:5] == BASE[31:5]) begin
            case (a[4:2])
                3'd0: r = s.mt[31:0];
                3'd1: r = s.shadow;
                3'd2: r = s.cmp[31:0];
                3'd3: r = s.cmp[63:32];
                3'd4: r = {29'd0, s.ctrl};
                3'd5: r = {16'd0, s.presc};
                3'd6: r = {31'd0, s.pend};
                default: r = s.period;
            endcase
        end
        return r;
    endfunction

    function automatic mstate_t m_step(mstate_t s, logic rd, logic wr, logic [31:0] a,
                                       logic [31:0] d, logic [2:0] mode);
        mstate_t n;
        logic inwin, w, en, tick, fire, clr, cmpw;
        logic [2:0] r;
        logic [63:0] bumped;
        n      = s;
        inwin  = (a[31:5] == BASE[31:5]);
        w      = wr && inwin && mode == 3'b010;
        r      = a[4:2];
        en     = s.ctrl[0];
        tick   = en && s.phase >= s.presc;
        fire   = en && s.armed && !s.fired && (s.mt >= s.cmp);
        clr    = w && r == 3'd6 && d[0];
        cmpw   = w && (r == 3'd2 || r == 3'd3);
        bumped = s.mt + (tick ? 64'd1 : 64'd0);
        n.phase = (!en || tick) ? 16'd0 : s.phase + 16'd1;
        n.mt    = bumped;
        if (w && r == 3'd0) n.mt = {s.mt[63:32], d};
        if (w && r == 3'd1) n.mt = {d, bumped[31:0]};
        if (rd && inwin && r == 3'd0) n.shadow = s.mt[63:32];
        if (fire && s.ctrl[1]) n.cmp = s.cmp + {32'd0, s.period};
        if (w && r == 3'd2) n.cmp[31:0]  = d;
        if (w && r == 3'd3) n.cmp[63:32] = d;
        if (w && r == 3'd4) n.ctrl   = d[2:0];
        if (w && r == 3'd5) n.presc  = d[15:0];
        if (w && r == 3'd7) n.period = d;
        n.pend  = fire ? 1'b1 : (clr ? 1'b0 : s.pend);
        n.armed = en;
        n.fired = en && (s.fired ? !(clr || cmpw) : (fire && !s.ctrl[1]));
        n.tint  = n.pend && n.ctrl[2];
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= M_RST;
        else      m <= m_step(m, bus.rd_en, bus.wr_en, bus.addr, bus.wdata, bus.mem_mode);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (go) begin
            chk("m_rdata",  64'(bus.rdata), 64'(m_rdata(m, bus.rd_en, bus.addr)));
            chk("m_hit",    64'(bus.hit),   64'(bus.addr[31:5] == BASE[31:5]));
            chk("m_t_intr", 64'(t_intr),    64'(m.tint));
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [2:0] mode = 3'b010);
        bus.wr_en = 1'b1; bus.addr = BASE + 32'(off); bus.wdata = d; bus.mem_mode = mode;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] off, output logic [31:0] d);
        bus.rd_en = 1'b1; bus.addr = BASE + 32'(off);
        @(negedge clk); d = bus.rdata;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] d;
        rd(off, d);
        chk(nm, 64'(d), 64'(exp));
    endtask

    task automatic do_reset();
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Waits at negedges for t_intr; n counts the low samples seen first.
    task automatic wait_tint(input int lim, output int n, output bit got);
        n = 0; got = 1'b0;
        for (int j = 0; j < lim && !got; j++) begin
            @(negedge clk);
            if (t_intr) got = 1'b1;
            else n++;
        end
    endtask

    task automatic rand_op();
        int k, r;
        logic [31:0] d;
        k = $urandom_range(0, 9);
        r = $urandom_range(0, 7);
        case (r)
            0: d = $urandom_range(0, 200);
            1: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            2: d = $urandom_range(0, 400);
            3: d = ($urandom_range(0, 15) == 0) ? 32'd1 : 32'd0;
            4: d = $urandom_range(0, 7);
            5: d = $urandom & 32'hFFFF_0003;
            6: d = $urandom;
            default: d = $urandom_range(0, 40);
        endcase
        bus.rd_en    = 1'($urandom_range(0, 1));
        bus.wr_en    = (k < 4);
        bus.wdata    = d;
        bus.mem_mode = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : MEM_WORD;
        bus.addr     = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
        if (k == 9) bus.addr = bus.addr + 32'h20;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, rise0, rise1, rise2, en_cyc;
        bit got;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = BASE;
        bus.wdata = '0; bus.mem_mode = MEM_WORD;
        #2 rst = 1'b0;
        go = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // reset values
        rdchk("rst_mtime_lo", OFF_MTIME_LO, 32'h0);
        rdchk("rst_mtime_hi", OFF_MTIME_HI, 32'h0);
        rdchk("rst_cmp_lo",   OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
        rdchk("rst_cmp_hi",   OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
        rdchk("rst_ctrl",     OFF_CTRL, 32'h0);
        rdchk("rst_presc",    OFF_PRESCALE, 32'h0);
        rdchk("rst_status",   OFF_STATUS, 32'h0);
        rdchk("rst_period",   OFF_PERIOD, 32'h0);
        bus.addr = BASE + 32'(OFF_MTIMECMP_LO);
        @(negedge clk);
        chk("nord_rdata", 64'(bus.rdata), 64'h0);
        chk("nord_hit",   64'(bus.hit), 64'h1);
        chk("rst_t_intr", 64'(t_intr), 64'h0);
        @(posedge clk); #1;

        // prescaler: one increment per 4 clocks
        wr(OFF_PRESCALE, 32'd3);
        wr(OFF_CTRL, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        rdchk("presc_count", OFF_MTIME_LO, 32'd10);
        wr(OFF_PRESCALE, 32'd5, 3'b000);
        rdchk("subword_ign", OFF_PRESCALE, 32'd3);
        wr(OFF_CTRL, 32'd0);

        // 32-bit carry and coherent LO/HI read
        wr(OFF_PRESCALE, 32'd0);
        wr(OFF_MTIME_LO, 32'hFFFF_FFFE);
        wr(OFF_MTIME_HI, 32'd0);
        wr(OFF_CTRL, 32'd1);
        @(posedge clk); #1;
        wr(OFF_CTRL, 32'd0);
        rdchk("carry_lo", OFF_MTIME_LO, 32'd0);
        rdchk("carry_hi", OFF_MTIME_HI, 32'd1);

        // one-shot
        do_reset();
        wr(OFF_MTIMECMP_LO, 32'd20);
        wr(OFF_MTIMECMP_HI, 32'd0);
        wr(OFF_CTRL, 32'd5);
        wait_tint(100, n, got);
        chk("os_got", 64'(got), 64'd1);
        chk("os_latency", 64'(n), 64'd21);
        @(posedge clk); #1;
        rdchk("os_pend", OFF_STATUS, 32'd1);
        wr(OFF_STATUS, 32'd1);
        @(negedge clk);
        chk("os_clr", 64'(t_intr), 64'd0);
        @(negedge clk);
        chk("os_reset", 64'(t_intr), 64'd1);
        @(posedge clk); #1;
        wr(OFF_CTRL, 32'd0);

        // periodic
        do_reset();
        wr(OFF_MTIMECMP_LO, 32'd10);
        wr(OFF_MTIMECMP_HI, 32'd0);
        wr(OFF_PERIOD, 32'd10);
        wr(OFF_CTRL, 32'd7);
        en_cyc = cyc;
        rise0 = 0; rise1 = 0; rise2 = 0;
        for (int p = 0; p < 3; p++) begin
            wait_tint(60, n, got);
            chk("per_got", 64'(got), 64'd1);
            if (p == 0) rise0 = cyc;
            else if (p == 1) rise1 = cyc;
            else rise2 = cyc;
            @(posedge clk); #1;
            wr(OFF_STATUS, 32'd1);
            @(negedge clk);
            chk("per_clr", 64'(t_intr), 64'd0);
            @(posedge clk); #1;
        end
        chk("per_first", 64'(rise0 - en_cyc), 64'd11);
        chk("per_gap1",  64'(rise1 - rise0), 64'd10);
        chk("per_gap2",  64'(rise2 - rise1), 64'd10);
        wr(OFF_CTRL, 32'd0);
        rdchk("per_cmp", OFF_MTIMECMP_LO, 32'd40);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            rand_op();
            @(posedge clk); #1;
        end
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;

        // async reset with an interrupt pending
        do_reset();
        wr(OFF_MTIMECMP_LO, 32'd2);
        wr(OFF_MTIMECMP_HI, 32'd0);
        wr(OFF_CTRL, 32'd5);
        wait_tint(50, n, got);
        chk("ar_got", 64'(got), 64'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1 chk("ar_t_intr", 64'(t_intr), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        rdchk("ar_ctrl",   OFF_CTRL, 32'd0);
        rdchk("ar_cmp_hi", OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
        rdchk("ar_status", OFF_STATUS, 32'd0);
        rdchk("ar_mtime",  OFF_MTIME_LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/mtimer_periph.md
Name: mtimer_periph

Overview:
- Memory-mapped machine-timer peripheral on the processor data-memory bus. It is the responder side of the load/store interface (rd_en, wr_en, addr, wdata, mem_mode).
- It is also the source of the processor's t_intr timer-interrupt input.
- Holds a 64-bit mtime counter with programmable prescaler, a 64-bit mtimecmp compare register, and a one-shot/periodic interrupt FSM.
- Reads are combinational, to suit the single-cycle datapath. All state updates on the clk rising edge.

Parameters:
- BASE_ADDR, 32'h0000_4000, base of the 32-byte register window; must be 32-byte aligned.
- PRESC_W, 16, width of the prescaler count and PRESCALE register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  load strobe
- wr_en  in  1  store strobe
- addr  in  32  byte address
- wdata  in  32  store data
- mem_mode  in  3  access size (funct3); only 3'b010 (word) is honoured for writes
- rdata  out  32  load data, combinational
- hit  out  1  addr[31:5]==BASE_ADDR[31:5]; integration uses it to select rdata over data_mem and to block the data_mem write
- t_intr  out  1  timer interrupt to processor CSR unit

Behaviour:
- Register map (offset, access):
  - 0x00 MTIME_LO rw
  - 0x04 MTIME_HI rw; read returns shadow
  - 0x08 MTIMECMP_LO rw
  - 0x0C MTIMECMP_HI rw
  - 0x10 CTRL rw: bit0 EN, bit1 PERIODIC, bit2 IE
  - 0x14 PRESCALE rw [PRESC_W-1:0]
  - 0x18 STATUS: bit0 PEND, write-1-to-clear
  - 0x1C PERIOD rw, 32-bit reload increment
- Reset (rst=0, async) sets:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF
  - CTRL=0, PRESCALE=0, PERIOD=0, PEND=0, shadow=0, prescale count=0
  - FSM=IDLE, t_intr=0
  - rdata=0 since no access is active. Reset mid-count discards all progress.
- Write: takes effect when wr_en & hit & mem_mode==3'b010 at the clk edge. Any other mem_mode write is ignored (no partial update).
- Read: rdata=register value when rd_en & hit, else 0. Unmapped bits read 0.
- Shadow: a read of MTIME_LO captures mtime[63:32] into the shadow at the clk edge. MTIME_HI reads return the shadow, giving a coherent LO-then-HI 64-bit read.
- Tick: while EN=1, the prescale count runs 0..PRESCALE.
  - tick=1 in the cycle count==PRESCALE; count then returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 holds the count at 0.
- mtime increments by 1 on tick and wraps from all-ones to 0.
  - A software write to MTIME_LO/HI in the same cycle wins over the increment, for the written half only.
  - Writing LO with a carry pending does not carry into HI that cycle.
- Match: match = (mtime >= mtimecmp), unsigned 64-bit, on registered values.
- FSM:
  - IDLE: EN=0. Go to RUN when EN=1.
  - RUN:
    - On match: set PEND.
    - If PERIODIC=1: mtimecmp <= mtimecmp + {32'b0,PERIOD}, 64-bit wrap; stay in RUN.
    - Else go to FIRED.
  - FIRED: no further PEND sets. Go to RUN when PEND is cleared or mtimecmp is written.
  - From any state, EN=0 → IDLE. PEND is unaffected.
- PEND set and W1C in the same cycle: set wins.
- A mtimecmp write in the same cycle as a periodic reload: the write wins.
- t_intr = PEND & IE, driven from flops, so it has no combinational path from bus inputs. It deasserts the cycle after the PEND clear edge.
- PERIOD=0 in PERIODIC mode: PEND re-sets every cycle while match holds. This is legal and documented.

Decomposition:
- Package mtimer_pkg holds:
  - register offset localparams (OFF_MTIME_LO … OFF_PERIOD)
  - CTRL bit indices (CTRL_EN, CTRL_PERIODIC, CTRL_IE)
  - MEM_WORD=3'b010
  - typedef enum logic [1:0] {IDLE, RUN, FIRED} tmr_state_e
- Sub-module: tick_gen (PRESC_W). Inputs clk, rst, en, prescale. Output tick.

Test Plan:
- Reset then read all 8 offsets → 0 except MTIMECMP_LO/HI=32'hFFFF_FFFF. t_intr=0. Read with rd_en=0 → rdata=0, hit=1.
- PRESCALE=3, EN=1 → mtime increments once per 4 clks. After 40 clks, MTIME_LO=10. A sub-word store (mem_mode=3'b000) to PRESCALE leaves it at 3.
- MTIME=32'hFFFF_FFFE/HI=0, EN=1, PRESCALE=0 → after 2 ticks LO=0, HI=1. The LO-read then HI-read pair returns a coherent {1,0}.
- One-shot: mtimecmp=20, IE=1, EN=1 → PEND and t_intr rise after mtime reaches 20. W1C to STATUS → t_intr=0 next cycle. Since match still holds, PEND re-sets one cycle after FIRED→RUN.
- Periodic: mtimecmp=10, PERIOD=10, PERIODIC=1 → PEND sets at mtime=10, 20, 30. Clearing PEND between matches produces three distinct t_intr pulses. mtimecmp reads 40 at the end.
- Assert rst low mid-count with PEND=1 → t_intr drops immediately (async). All registers return to reset values.
